prog_loader: RTL and testbench
==============================

# prog_loader

Boot-time program loader that sits directly upstream of the single-cycle RV32I core's instruction memory. It accepts a framed little-endian byte stream over a valid/ready interface and assembles 32-bit words. It writes the words sequentially into instruction memory and checks an XOR checksum. The core is held in reset until a frame completes with a matching checksum.

## Interface
- `DEPTH_WORDS`, 256, instruction-memory capacity in words; larger word counts are rejected
- `BASE_ADDR`, 32'h0000_0000, byte address of the first written word
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- `in_valid`  in  1  `in_byte` holds a valid byte
- `in_byte`  in  8  stream byte
- `in_ready`  out  1  loader accepts a byte this cycle
- `restart`  in  1  single-cycle pulse; re-arms the loader from DONE or ERROR
- `im_we`  out  1  instruction-memory write strobe, one cycle per word
- `im_addr`  out  32  byte address of the word being written
- `im_wdata`  out  32  word being written
- `core_reset`  out  1  active-high reset to the core; high unless in DONE
- `done`  out  1  frame loaded and checksum matched
- `error`  out  1  frame rejected (oversize count or checksum mismatch)
- `words_loaded`  out  16  number of words written in the current or last frame

## Operation
- Frame format: `CNT_LO`, `CNT_HI` (16-bit word count N), then 4·N payload bytes, each word least-significant byte first, then one `CSUM` byte.
- `CSUM` must equal the XOR of all payload bytes; the count bytes are not included.
- A byte is transferred when `in_valid && in_ready`. Bytes presented while `in_ready` is low are ignored, not buffered.
- States: `S_CNT_LO` → `S_CNT_HI` → `S_DATA` → `S_CSUM` → `S_DONE` | `S_ERROR`.
- `S_CNT_LO`: latch the low count byte; clear the checksum accumulator, byte index and `words_loaded`.
- `S_CNT_HI`: latch the high count byte and form N.
  - If N > `DEPTH_WORDS`, go to `S_ERROR`.
  - If N == 0, go to `S_CSUM`.
  - Otherwise go to `S_DATA`.
- `S_DATA`:
  - Shift each byte into the word assembler at lane = byte index mod 4, and XOR it into the accumulator.
  - On lane 3, issue a write and increment `words_loaded` (16-bit).
  - After word N, go to `S_CSUM`.
- `S_CSUM`:
  - On a match, go to `S_DONE`.
  - On a mismatch, go to `S_ERROR`.
  - In both cases no memory write occurs.
- `S_DONE` and `S_ERROR` are sticky. `restart` returns to `S_CNT_LO`; `restart` in any other state is ignored.
- Address of word k: `BASE_ADDR` + 4·k, modulo 2^32 (wraps; no saturation).
- `in_ready` is 1 in `S_CNT_LO`, `S_CNT_HI`, `S_DATA` and `S_CSUM`, and 0 in `S_DONE` and `S_ERROR`.
- `done` = (state == `S_DONE`), `error` = (state == `S_ERROR`), `core_reset` = !`done`. All three are registered.
- On an error, words already written remain in memory; the core stays in reset.

## Timing
- Reset values:
  - state `S_CNT_LO`
  - `in_ready` = 1
  - `im_we` = 0, `im_addr` = `BASE_ADDR`, `im_wdata` = 0
  - `core_reset` = 1, `done` = 0, `error` = 0
  - `words_loaded` = 0
- Reset asserted mid-frame aborts immediately to the reset values; no partial write is emitted.
- Write latency: `im_we` is high exactly one cycle, in the cycle after the lane-3 byte is accepted. `im_addr` and `im_wdata` are valid in that same cycle.
- Back-to-back bytes are accepted every cycle (the loader never stalls `in_ready` inside a frame). The maximum write rate is therefore one word every 4 cycles.
- `done` and `error` rise, and `core_reset` falls, one cycle after the `CSUM` byte is accepted.
- After a `restart` pulse, the loader is in `S_CNT_LO` on the next cycle: `core_reset` = 1 and `done`/`error` = 0.
- `restart` and `in_valid` in the same cycle in `S_DONE`: `restart` wins and the byte is not accepted.

## Structure
- Package `loader_pkg`:
  - `typedef enum logic [2:0] loader_state_t` with the six states
  - localparam `LOADER_CNT_W` = 16
- Single module `prog_loader`, with no sub-module.
- The word assembler and checksum accumulator are inline registers.
- Intended top-level hookup:
  - `im_*` → instruction-memory write port
  - `core_reset` → core reset

## Test plan
- Two-word frame, bytes 02 00 93 00 50 00 13 01 10 00 C1 sent back to back:
  - `im_we` at `im_addr` 0x0 with 0x00500093, then at 0x4 with 0x00100113
  - then `done` = 1, `core_reset` = 0, `words_loaded` = 2
- Same frame with checksum 0xC0 → both writes occur, then `error` = 1 and `core_reset` stays 1.
- Count 0x0101 (257) with default `DEPTH_WORDS` → `error` after `CNT_HI`, no `im_we` pulses, `in_ready` = 0.
- Zero-count frame 00 00 00 → `done` = 1 with no writes; then a `restart` pulse → `core_reset` = 1, and the two-word frame reloads.
- Two-word frame with `in_valid` toggling randomly → identical writes and result. Bytes held while `in_ready` = 0 in `S_DONE` are not consumed.
- Reset pulsed low after the 6th payload byte → all outputs return to reset values. A fresh full frame then loads correctly starting at `BASE_ADDR`.

Source files
------------

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state encoding and widths for the boot program loader
package loader_pkg;

  localparam int LOADER_CNT_W = 16;

  typedef enum logic [2:0] {
    S_CNT_LO = 3'd0,
    S_CNT_HI = 3'd1,
    S_DATA   = 3'd2,
    S_CSUM   = 3'd3,
    S_DONE   = 3'd4,
    S_ERROR  = 3'd5
  } loader_state_t;

endpackage

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte stream to instruction-memory loader with XOR checksum gate
module prog_loader
  import loader_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [7:0]              in_byte,
  output logic                    in_ready,
  input  logic                    restart,
  output logic                    im_we,
  output logic [31:0]             im_addr,
  output logic [31:0]             im_wdata,
  output logic                    core_reset,
  output logic                    done,
  output logic                    error,
  output logic [LOADER_CNT_W-1:0] words_loaded
);

  localparam logic [LOADER_CNT_W:0] DEPTH_L = (LOADER_CNT_W+1)'(DEPTH_WORDS);

  loader_state_t state, state_next;

  logic [7:0]              cnt_lo;
  logic [LOADER_CNT_W-1:0] word_cnt;
  logic [1:0]              byte_idx;
  logic [7:0]              csum;
  logic [23:0]             asm_q;

  logic                    accept;
  logic [LOADER_CNT_W-1:0] n_full;
  logic                    last_word;

  assign in_ready  = (state != S_DONE) && (state != S_ERROR);
  assign accept    = in_valid && in_ready;
  assign n_full    = {in_byte, cnt_lo};
  assign last_word = ((words_loaded + 16'd1) == word_cnt);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_CNT_LO;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_CNT_LO: if (accept) state_next = S_CNT_HI;
      S_CNT_HI: begin
        if (accept) begin
          if ({1'b0, n_full} > DEPTH_L) state_next = S_ERROR;
          else if (n_full == '0)        state_next = S_CSUM;
          else                          state_next = S_DATA;
        end
      end
      S_DATA:   if (accept && (byte_idx == 2'd3) && last_word) state_next = S_CSUM;
      S_CSUM:   if (accept) state_next = (in_byte == csum) ? S_DONE : S_ERROR;
      S_DONE,
      S_ERROR:  if (restart) state_next = S_CNT_LO;
      default:  state_next = S_CNT_LO;
    endcase
  end

  // Status flags are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im_we        <= 1'b0;
      im_addr      <= BASE_ADDR;
      im_wdata     <= '0;
      core_reset   <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      cnt_lo       <= '0;
      word_cnt     <= '0;
      byte_idx     <= '0;
      csum         <= '0;
      asm_q        <= '0;
    end else begin
      im_we      <= 1'b0;
      done       <= (state_next == S_DONE);
      error      <= (state_next == S_ERROR);
      core_reset <= (state_next != S_DONE);
      if (accept) begin
        case (state)
          S_CNT_LO: begin
            cnt_lo       <= in_byte;
            csum         <= '0;
            byte_idx     <= '0;
            words_loaded <= '0;
          end
          S_CNT_HI: word_cnt <= n_full;
          S_DATA: begin
            csum     <= csum ^ in_byte;
            byte_idx <= byte_idx + 2'd1;
            // Lanes 0..2 shift in from the top so lane 0 ends up in the low byte.
            if (byte_idx == 2'd3) begin
              im_we        <= 1'b1;
              im_wdata     <= {in_byte, asm_q};
              im_addr      <= BASE_ADDR + {14'd0, words_loaded, 2'b00};
              words_loaded <= words_loaded + 16'd1;
            end else begin
              asm_q <= {in_byte, asm_q[23:8]};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - scoreboard bench for prog_loader frame loading, checksum and restart
module tb_prog_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        restart = 1'b0;
  logic        in_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic        core_reset;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] exp_q[$];
  logic [63:0] mon_e;
  logic [31:0] words[$];
  logic [31:0] no_words[$];
  logic [7:0]  fr[$];
  logic [7:0]  part[$];

  prog_loader dut (
    .clk          (clk),
    .reset        (rst_n),
    .in_valid     (in_valid),
    .in_byte      (in_byte),
    .in_ready     (in_ready),
    .restart      (restart),
    .im_we        (im_we),
    .im_addr      (im_addr),
    .im_wdata     (im_wdata),
    .core_reset   (core_reset),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && im_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("we_unexpected", {31'b0, im_we}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("im_addr", im_addr, mon_e[63:32]);
        check_eq("im_wdata", im_wdata, mon_e[31:0]);
      end
    end
  end

  task automatic make_frame(input logic [31:0] w[$], input logic [15:0] n,
                            input logic [7:0] bad, output logic [7:0] f[$]);
    logic [7:0] x;
    logic [31:0] wd;
    f = {};
    x = 8'h00;
    f.push_back(n[7:0]);
    f.push_back(n[15:8]);
    foreach (w[i]) begin
      wd = w[i];
      for (int b = 0; b < 4; b++) begin
        f.push_back(wd[8*b +: 8]);
        x = x ^ wd[8*b +: 8];
      end
    end
    f.push_back(x ^ bad);
  endtask

  task automatic expect_words(input logic [31:0] w[$], input int cnt);
    for (int k = 0; k < cnt; k++) exp_q.push_back({BASE + 32'(4 * k), w[k]});
  endtask

  task automatic send(input logic [7:0] f[$], input bit rnd);
    foreach (f[i]) begin
      int guard;
      bit acc;
      guard = 0;
      acc = 1'b0;
      while (!acc) begin
        in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        in_byte  = f[i];
        @(negedge clk);
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
        guard++;
        if (!acc && guard > 100) begin
          in_valid = 1'b0;
          check_eq("send_timeout", {31'b0, in_ready}, 32'd1);
          return;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    check_eq({tag, "_im_we"}, {31'b0, im_we}, 32'd0);
    check_eq({tag, "_im_addr"}, im_addr, BASE);
    check_eq({tag, "_im_wdata"}, im_wdata, 32'd0);
    check_eq({tag, "_core_reset"}, {31'b0, core_reset}, 32'd1);
    check_eq({tag, "_done"}, {31'b0, done}, 32'd0);
    check_eq({tag, "_error"}, {31'b0, error}, 32'd0);
    check_eq({tag, "_words_loaded"}, {16'b0, words_loaded}, 32'd0);
  endtask

  task automatic check_result(input string tag, input bit exp_done, input logic [15:0] exp_wl);
    check_eq({tag, "_done"}, {31'b0, done}, {31'b0, exp_done});
    check_eq({tag, "_error"}, {31'b0, error}, {31'b0, !exp_done});
    check_eq({tag, "_core_reset"}, {31'b0, core_reset}, {31'b0, !exp_done});
    check_eq({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
    check_eq({tag, "_words_loaded"}, {16'b0, words_loaded}, {16'b0, exp_wl});
    check_eq({tag, "_q_empty"}, exp_q.size(), 32'd0);
  endtask

  task automatic pulse_restart(input string tag);
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart  = 1'b0;
    in_valid = 1'b0;
    check_eq({tag, "_core_reset"}, {31'b0, core_reset}, 32'd1);
    check_eq({tag, "_done"}, {31'b0, done}, 32'd0);
    check_eq({tag, "_error"}, {31'b0, error}, 32'd0);
    check_eq({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    words = {32'h00500093, 32'h00100113};
    no_words = {};

    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    make_frame(words, 16'd2, 8'h00, fr);
    expect_words(words, 2);
    send(fr, 1'b0);
    check_result("two_word", 1'b1, 16'd2);
    pulse_restart("rs1");

    make_frame(words, 16'd2, 8'h01, fr);
    expect_words(words, 2);
    send(fr, 1'b0);
    check_result("bad_csum", 1'b0, 16'd2);
    pulse_restart("rs2");

    part = {8'h01, 8'h01};
    send(part, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_result("oversize", 1'b0, 16'd0);
    pulse_restart("rs3");

    make_frame(no_words, 16'd0, 8'h00, fr);
    send(fr, 1'b0);
    check_result("zero_cnt", 1'b1, 16'd0);
    pulse_restart("rs4");
    make_frame(words, 16'd2, 8'h00, fr);
    expect_words(words, 2);
    send(fr, 1'b0);
    check_result("reload", 1'b1, 16'd2);
    pulse_restart("rs5");

    expect_words(words, 2);
    send(fr, 1'b1);
    check_result("rand_valid", 1'b1, 16'd2);
    in_valid = 1'b1;
    in_byte  = 8'h05;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_eq("held_in_ready", {31'b0, in_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    check_eq("held_done", {31'b0, done}, 32'd1);
    pulse_restart("rs_vs_valid");
    make_frame(no_words, 16'd0, 8'h00, fr);
    send(fr, 1'b0);
    check_result("after_held", 1'b1, 16'd0);

    pulse_restart("rs6");
    make_frame(words, 16'd2, 8'h00, fr);
    part = fr[0:7];
    expect_words(words, 1);
    send(part, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    @(posedge clk);
    #1;
    check_reset_vals("mid_rst_hold");
    rst_n = 1'b1;
    check_eq("mid_rst_q_empty", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
    expect_words(words, 2);
    send(fr, 1'b0);
    check_result("post_rst", 1'b1, 16'd2);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
